// File: rtl/rijndael_pkg.sv
// rtl/rijndael_pkg.sv - shared Rijndael state layout helpers and skid-buffer state type
package rijndael_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Row offsets: wide blocks (NB = 8) skip offset 2 on the lower two rows
    function automatic int shift_amt(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    function automatic int idx(input int r, input int c);
        return 32 * c + BYTE_W * r;
    endfunction

endpackage

// File: rtl/rows_permute.sv
// rtl/rows_permute.sv - combinational ShiftRows / InvShiftRows byte permutation
module rows_permute #(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] state_o
);
    import rijndael_pkg::*;

    // Source columns are elaboration-time constants, so each byte is a 2:1 mux
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SH      = shift_amt(NB, r);
            localparam int FWD_SRC = (c + SH) % NB;
            localparam int INV_SRC = (c + NB - SH) % NB;

            assign state_o[idx(r, c) +: BYTE_W] = inv_i ? state_i[idx(r, INV_SRC) +: BYTE_W]
                                                        : state_i[idx(r, FWD_SRC) +: BYTE_W];
        end
    end

endmodule

// File: rtl/shiftrows_pipe.sv
// rtl/shiftrows_pipe.sv - registered ShiftRows stage with 2-entry skid buffer and tag sideband
module shiftrows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [32*NB-1:0]   in_state,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_state,
    output logic [TAG_W-1:0]   out_tag
);
    import rijndael_pkg::*;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shiftrows_pipe: TAG_W must be at least 1");
    end

    localparam int SW = 32 * NB;

    logic [SW-1:0]    perm;
    skid_state_e      state_q, state_d;
    logic [SW-1:0]    m_state_q, m_state_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic [SW-1:0]    s_state_q, s_state_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;
    logic             acc;
    logic             pop;

    // Direction is consumed here, so only the permuted block is stored
    rows_permute #(.NB(NB)) u_rows_permute (
        .state_i (in_state),
        .inv_i   (in_inv),
        .state_o (perm)
    );

    // Ready depends only on the registered skid occupancy (and reset)
    assign in_ready  = !rst && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_state = m_state_q;
    assign out_tag   = m_tag_q;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        m_state_d = m_state_q;
        m_tag_d   = m_tag_q;
        s_state_d = s_state_q;
        s_tag_d   = s_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d   = ST_ONE;
                    m_state_d = perm;
                    m_tag_d   = in_tag;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    m_state_d = perm;
                    m_tag_d   = in_tag;
                end else if (acc) begin
                    state_d   = ST_FULL;
                    s_state_d = perm;
                    s_tag_d   = in_tag;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d   = ST_ONE;
                    m_state_d = s_state_q;
                    m_tag_d   = s_tag_q;
                    s_state_d = '0;
                    s_tag_d   = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            m_state_q <= '0;
            m_tag_q   <= '0;
            s_state_q <= '0;
            s_tag_q   <= '0;
        end else begin
            state_q   <= state_d;
            m_state_q <= m_state_d;
            m_tag_q   <= m_tag_d;
            s_state_q <= s_state_d;
            s_tag_q   <= s_tag_d;
        end
    end

endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb/tb_shiftrows_pipe.sv - directed and random self-checking bench for shiftrows_pipe
module tb_shiftrows_pipe;

    logic clk;
    logic rst;

    logic         in_valid, in_inv, out_ready;
    logic [127:0] in_state;
    logic [7:0]   in_tag;
    logic         in_ready, out_valid;
    logic [127:0] out_state;
    logic [7:0]   out_tag;

    logic         w_inv, v6, v8;
    logic [255:0] w_state;
    logic [7:0]   w_tag;
    logic         r6, r8, ov6, ov8;
    logic [191:0] o6_state;
    logic [255:0] o8_state;
    logic [7:0]   o6_tag, o8_tag;
    logic         one;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    typedef struct {
        logic [127:0] st;
        logic [7:0]   tg;
    } exp_t;
    exp_t sb[$];

    logic         stall_q = 1'b0;
    logic [127:0] held_state;
    logic [7:0]   held_tag;

    shiftrows_pipe #(.NB(4), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_tag(out_tag)
    );

    shiftrows_pipe #(.NB(6), .TAG_W(8)) dut6 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in_inv(w_inv),
        .in_state(w_state[191:0]), .in_tag(w_tag), .out_valid(ov6), .out_ready(one),
        .out_state(o6_state), .out_tag(o6_tag)
    );

    shiftrows_pipe #(.NB(8), .TAG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_inv(w_inv),
        .in_state(w_state), .in_tag(w_tag), .out_valid(ov8), .out_ready(one),
        .out_state(o8_state), .out_tag(o8_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_perm(input logic [255:0] s, input int nb, input logic inv);
        int sh [4];
        int src;
        logic [255:0] o;
        o = '0;
        if (nb == 8) sh = '{0, 1, 3, 4};
        else         sh = '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
                o[32*c + 8*r +: 8] = s[32*src + 8*r +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [127:0] st, input logic inv, input logic [7:0] tg);
        in_state = st;
        in_inv   = inv;
        in_tag   = tg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic xfer(input int nb, input logic [255:0] x, input logic inv, output logic [255:0] y);
        w_state = x;
        w_inv   = inv;
        if (nb == 6) v6 = 1'b1;
        else         v8 = 1'b1;
        tick();
        v6 = 1'b0;
        v8 = 1'b0;
        @(negedge clk);
        if (nb == 6) begin
            y = {64'b0, o6_state};
            check("nb6_valid", ov6, 1'b1);
        end else begin
            y = o8_state;
            check("nb8_valid", ov8, 1'b1);
        end
        tick();
    endtask

    // Scoreboard: occupancy model, FIFO order, per-block direction, stall stability
    always @(negedge clk) begin
        exp_t e;
        logic [255:0] t;
        if (rst) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            check("in_ready", in_ready, sb.size() < 2);
            check("out_valid", out_valid, sb.size() > 0);
            if (stall_q) begin
                check("hold_state", out_state, held_state);
                check("hold_tag", out_tag, held_tag);
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("out_state", out_state, e.st);
                    check("out_tag", out_tag, e.tg);
                end
            end
            stall_q    = out_valid && !out_ready;
            held_state = out_state;
            held_tag   = out_tag;
            if (in_valid && in_ready) begin
                t    = ref_perm({128'b0, in_state}, 4, in_inv);
                e.st = t[127:0];
                e.tg = in_tag;
                sb.push_back(e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] vec, y4;
        logic [255:0] x, y, z, pat;
        logic [7:0]   got [$];
        logic         drop, acc;
        int           p0, sent, cyc;

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0;
        in_state = '0; in_tag = '0;
        w_state = '0; w_inv = 1'b0; w_tag = '0; v6 = 1'b0; v8 = 1'b0; one = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_state", out_state, 128'h0);
        check("rst_out_tag", out_tag, 8'h0);
        check("rst_nb8_valid", ov8, 1'b0);
        tick();

        // NB = 4 hand-computed vectors
        vec = 128'h0f0e0d0c0b0a09080706050403020100;
        out_ready = 1'b1;
        send_one(vec, 1'b0, 8'h11);
        @(negedge clk);
        check("t1_valid", out_valid, 1'b1);
        check("t1_state", out_state, 128'h0b06010c07020d08030e09040f0a0500);
        check("t1_tag", out_tag, 8'h11);
        tick();
        send_one(128'h0b06010c07020d08030e09040f0a0500, 1'b1, 8'h22);
        @(negedge clk);
        check("t2_state", out_state, vec);
        tick();
        send_one(vec, 1'b1, 8'h33);
        @(negedge clk);
        check("t2_inv_vec", out_state, 128'h0306090c0f0205080b0e0104070a0d00);
        tick();
        for (int k = 0; k < 3; k++) begin
            vec = rand128();
            send_one(vec, 1'b0, 8'h40);
            @(negedge clk);
            y4 = out_state;
            tick();
            send_one(y4, 1'b1, 8'h41);
            @(negedge clk);
            check("nb4_roundtrip", out_state, vec);
            tick();
        end

        // NB = 6 / 8: byte (r,c) = {r,c} nibbles, then random round trips
        pat = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                pat[32*c + 8*r +: 8] = {r[3:0], c[3:0]};
        xfer(8, pat, 1'b0, y);
        check("nb8_r3c0_fwd", y[31:24], 8'h34);
        check("nb8_r2c0_fwd", y[23:16], 8'h23);
        check("nb8_r1c7_fwd", y[239:232], 8'h10);
        xfer(8, pat, 1'b1, y);
        check("nb8_r2c0_inv", y[23:16], 8'h25);
        x = pat;
        x[255:192] = '0;
        xfer(6, x, 1'b0, y);
        check("nb6_r3c5_fwd", y[191:184], 8'h32);
        xfer(6, x, 1'b1, y);
        check("nb6_r2c1_inv", y[55:48], 8'h25);
        for (int k = 0; k < 4; k++) begin
            x = {rand128(), rand128()};
            xfer(8, x, 1'b0, y);
            check("nb8_fwd_model", y, ref_perm(x, 8, 1'b0));
            xfer(8, y, 1'b1, z);
            check("nb8_roundtrip", z, x);
            x[255:192] = '0;
            xfer(6, x, 1'b0, y);
            check("nb6_fwd_model", y, ref_perm(x, 6, 1'b0));
            xfer(6, y, 1'b1, z);
            check("nb6_roundtrip", z, x);
        end

        // Backpressure: third block must wait until the skid drains
        out_ready = 1'b0;
        in_valid  = 1'b1; in_inv = 1'b0;
        in_tag = 8'd1; in_state = rand128();
        tick();
        in_tag = 8'd2; in_state = rand128();
        tick();
        in_tag = 8'd3; in_state = rand128();
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_head_tag", out_tag, 8'd1);
        tick();
        @(negedge clk);
        check("bp_in_ready_hold", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_tag);
            drop = in_valid && in_ready;
            tick();
            if (drop) in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++)
            check("bp_order", got[i], i + 1);

        // Streaming, alternating direction
        p0 = n_pop;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_inv = i[0];
            in_tag = i[7:0];
            in_state = rand128();
            @(negedge clk);
            check("stream_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("stream_count", n_pop - p0, 100);

        // Reset with a full pipe
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag = 8'hA1; in_state = rand128();
        tick();
        in_tag = 8'hA2; in_state = rand128();
        tick();
        in_tag = 8'hA3; in_state = rand128();
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_out", out_valid, 1'b0);
            tick();
        end

        // Random backpressure, 10k blocks
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            tick();
            cyc++;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_inv   = $urandom_range(0, 1);
                in_tag   = $urandom_range(0, 255);
                in_state = rand128();
            end
            out_ready = $urandom_range(0, 1);
        end
        check("rand_sent", sent, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("rand_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
